// File: rtl/svlib_pipe_pkg.sv
// rtl/svlib_pipe_pkg.sv - shared pipeline-stage types and helpers
package svlib_pipe_pkg;

  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_ONE   = 2'd1,
    SKID_TWO   = 2'd2
  } skid_state_t;

  // Occupancy is the state encoding itself, so the count costs no extra logic.
  function automatic logic [1:0] skid_occupancy(input skid_state_t s);
    return s;
  endfunction

endpackage

// File: rtl/skid_buffer_flush_arstn.sv
// rtl/skid_buffer_flush_arstn.sv - two-entry skid buffer with registered s_ready and synchronous flush
module skid_buffer_flush_arstn
  import svlib_pipe_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             flush,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic [1:0]       occupancy
);

  skid_state_t      state_q, state_d;
  logic [WIDTH-1:0] main_data_q, main_data_d;
  logic [WIDTH-1:0] skid_data_q, skid_data_d;
  logic             s_ready_q, s_ready_d;
  logic             main_valid;
  logic             push;
  logic             pop;

  assign main_valid = (state_q != SKID_EMPTY);
  assign m_valid    = main_valid & ~flush;
  assign m_data     = flush ? '0 : main_data_q;
  assign push       = s_valid & s_ready_q & ~flush;
  assign pop        = m_valid & m_ready;
  assign s_ready    = s_ready_q;
  assign occupancy  = skid_occupancy(state_q);

  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    skid_data_d = skid_data_q;
    if (flush) begin
      state_d     = SKID_EMPTY;
      main_data_d = '0;
      skid_data_d = '0;
    end else begin
      case (state_q)
        SKID_EMPTY: begin
          if (push) begin
            state_d     = SKID_ONE;
            main_data_d = s_data;
          end
        end
        SKID_ONE: begin
          if (push && pop) begin
            main_data_d = s_data;
          end else if (push) begin
            state_d     = SKID_TWO;
            skid_data_d = s_data;
          end else if (pop) begin
            state_d = SKID_EMPTY;
          end
        end
        SKID_TWO: begin
          // s_ready is low here, so the only way out is draining main.
          if (pop) begin
            state_d     = SKID_ONE;
            main_data_d = skid_data_q;
          end
        end
        default: state_d = SKID_EMPTY;
      endcase
    end
    s_ready_d = (state_d != SKID_TWO);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= SKID_EMPTY;
      main_data_q <= '0;
      skid_data_q <= '0;
      s_ready_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      skid_data_q <= skid_data_d;
      s_ready_q   <= s_ready_d;
    end
  end

endmodule

// File: tb/tb_skid_buffer_flush_arstn.sv
// tb/tb_skid_buffer_flush_arstn.sv - scoreboard bench for skid_buffer_flush_arstn
module tb_skid_buffer_flush_arstn;

  logic        clk;
  logic        rstn;
  logic        flush;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_data;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_data;
  logic [1:0]  occupancy;

  skid_buffer_flush_arstn #(.WIDTH(32)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .flush     (flush),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .occupancy (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_pass  = 0;
  int          n_total = 0;
  logic [31:0] q[$];
  logic [31:0] emitted[$];
  logic        s_rdy_m = 1'b0;
  logic        prev_hold = 1'b0;
  logic [31:0] prev_data = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
  endtask

  // Expected beats enter the queue at the edge that accepts them.
  always @(posedge clk) begin
    if (rstn) begin
      if (flush) q.delete();
      else if (s_valid && s_rdy_m) q.push_back(s_data);
      s_rdy_m = (q.size() != 2);
    end else begin
      s_rdy_m = 1'b0;
    end
  end

  // Output monitor: compares every cycle and pops on each completed transfer.
  always @(negedge clk) begin
    logic exp_v;
    if (!rstn) begin
      chk("rst_m_valid", {31'd0, m_valid}, 32'd0);
      chk("rst_s_ready", {31'd0, s_ready}, 32'd0);
      chk("rst_occupancy", {30'd0, occupancy}, 32'd0);
      chk("rst_m_data", m_data, 32'd0);
      q.delete();
      s_rdy_m   = 1'b0;
      prev_hold = 1'b0;
    end else begin
      exp_v = (q.size() > 0) && !flush;
      chk("s_ready", {31'd0, s_ready}, {31'd0, s_rdy_m});
      chk("occupancy", {30'd0, occupancy}, q.size());
      chk("m_valid", {31'd0, m_valid}, {31'd0, exp_v});
      if (exp_v) chk("m_data", m_data, q[0]);
      if (flush) chk("flush_m_data", m_data, 32'd0);
      if (prev_hold && !flush) chk("stall_stable", m_data, prev_data);
      prev_hold = m_valid && !m_ready && !flush;
      prev_data = m_data;
      if (exp_v && m_ready) begin
        emitted.push_back(m_data);
        void'(q.pop_front());
      end
    end
  end

  task automatic step(input logic sv, input logic [31:0] sd, input logic mr, input logic fl);
    @(posedge clk);
    #1;
    s_valid = sv;
    s_data  = sd;
    m_ready = mr;
    flush   = fl;
  endtask

  logic [31:0] exp_list[$];
  logic        hold;

  initial begin
    rstn = 1'b0; flush = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b1;
    exp_list = '{32'h1, 32'h2, 32'h3, 32'h4, 32'h5, 32'h6, 32'h7, 32'h8,
                 32'hA, 32'hB, 32'h5, 32'h6, 32'h3};

    // Reset, then streaming
    repeat (3) step(1'b0, 32'h0, 1'b1, 1'b0);
    @(posedge clk); #1; rstn = 1'b1;
    step(1'b0, 32'h0, 1'b1, 1'b0);
    for (int i = 1; i <= 8; i++) step(1'b1, i, 1'b1, 1'b0);
    repeat (2) step(1'b0, 32'h0, 1'b1, 1'b0);

    // Stall fill, then drain
    step(1'b1, 32'hA, 1'b0, 1'b0);
    step(1'b1, 32'hB, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0);

    // Simultaneous push/pop in ONE
    step(1'b1, 32'h5, 1'b0, 1'b0);
    step(1'b1, 32'h6, 1'b1, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0);

    // Flush while TWO
    step(1'b1, 32'hA, 1'b0, 1'b0);
    step(1'b1, 32'hB, 1'b0, 1'b0);
    step(1'b1, 32'hC, 1'b0, 1'b1);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0);

    // Async reset mid-stall
    step(1'b1, 32'hD, 1'b0, 1'b0);
    step(1'b1, 32'hE, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    @(posedge clk); #3; rstn = 1'b0;
    @(posedge clk); #1; rstn = 1'b1;
    step(1'b0, 32'h0, 1'b1, 1'b0);
    step(1'b1, 32'h3, 1'b1, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    @(negedge clk);

    chk("emitted_count", emitted.size(), exp_list.size());
    for (int i = 0; i < exp_list.size(); i++) begin
      if (i < emitted.size()) chk("emitted_beat", emitted[i], exp_list[i]);
    end
    emitted.delete();

    // Random handshake soak; upstream holds its beat until accepted or flushed
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      hold = s_valid && !s_ready && !flush;
      @(posedge clk); #1;
      flush   = ($urandom_range(0, 99) < 2);
      m_ready = 1'($urandom_range(0, 1));
      if (!hold) begin
        s_valid = 1'($urandom_range(0, 1));
        s_data  = $urandom;
      end
    end
    @(negedge clk);
    hold = s_valid && !s_ready && !flush;
    step(hold, s_data, 1'b1, 1'b0);
    repeat (4) step(1'b0, 32'h0, 1'b1, 1'b0);
    @(negedge clk);
    chk("soak_drained", q.size(), 32'd0);
    chk("soak_emitted_some", {31'd0, emitted.size() > 1000}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
